ldst_mem_issuer: RTL and testbench

//  Head-of-queue consumer for the load/store buffer. Takes the oldest ldst entry, drives the

---
 rtl/ldst_mem_issuer.sv | 97 +++++++++
 tb/tb_ldst_mem_issuer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ldst_mem_issuer.sv
// ldst_mem_issuer: pops the oldest load/store entry, drives the D-cache port and reports results on the CDB.
module ldst_mem_issuer #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_flush,
  input  logic              i_head_valid,
  input  logic              i_head_ready,
  input  logic              i_head_is_store,
  input  logic              i_head_byte,
  input  logic [DATA_W-1:0] i_head_addr,
  input  logic [DATA_W-1:0] i_head_wdata,
  input  logic [TAG_W-1:0]  i_head_tag,
  input  logic              i_rob_head_valid,
  input  logic [TAG_W-1:0]  i_rob_head_tag,
  output logic              o_ldst_re,
  output logic              o_dmem_read,
  output logic              o_dmem_write,
  output logic [DATA_W-1:0] o_dmem_address,
  output logic [DATA_W-1:0] o_dmem_wdata,
  output logic [1:0]        o_dmem_byte_enable,
  input  logic              i_dmem_resp,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  output logic              o_cdb_valid,
  output logic [TAG_W-1:0]  o_cdb_tag,
  output logic [DATA_W-1:0] o_cdb_data,
  input  logic              i_cdb_grant,
  output logic              o_store_done,
  output logic [TAG_W-1:0]  o_store_done_tag,
  output logic              o_busy
);
  typedef enum logic [2:0] {IDLE, LD_REQ, ST_REQ, BCAST, DRAIN} state_t;
  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_addr, r_wdata, r_result, w_ld_data;
  logic [TAG_W-1:0]  r_tag;
  logic              r_byte, r_dmem_read, r_dmem_write;
  logic              w_go_ld, w_go_st, w_req, w_bcast;
  logic [7:0]        w_lane;
  logic [1:0]        w_be;
  assign w_go_ld   = ~i_flush & i_head_valid & i_head_ready & ~i_head_is_store;
  assign w_go_st   = ~i_flush & i_head_valid & i_head_ready & i_head_is_store &
                     i_rob_head_valid & (i_rob_head_tag == i_head_tag);
  assign w_req     = r_dmem_read | r_dmem_write;
  assign w_bcast   = r_state == BCAST;
  assign w_lane    = r_addr[0] ? i_dmem_rdata[8 +: 8] : i_dmem_rdata[7:0];
  assign w_ld_data = r_byte ? {{(DATA_W-8){w_lane[7]}}, w_lane} : i_dmem_rdata;
  assign w_be      = ~r_byte ? 2'b11 : r_addr[0] ? 2'b10 : 2'b01;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_go_ld ? LD_REQ : w_go_st ? ST_REQ : IDLE;
      LD_REQ:  w_next = i_dmem_resp ? (i_flush ? IDLE : BCAST) : (i_flush ? DRAIN : LD_REQ);
      ST_REQ:  w_next = i_dmem_resp ? IDLE : ST_REQ;
      BCAST:   w_next = (i_cdb_grant | i_flush) ? IDLE : BCAST;
      DRAIN:   w_next = i_dmem_resp ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_tag        <= '0;
      r_byte       <= 1'b0;
      r_result     <= '0;
      r_dmem_read  <= 1'b0;
      r_dmem_write <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_dmem_read  <= (w_next == LD_REQ) | (w_next == DRAIN);
      r_dmem_write <= w_next == ST_REQ;
      if (r_state == IDLE && w_next != IDLE) begin
        r_addr  <= i_head_addr;
        r_wdata <= i_head_byte ? {(DATA_W/8){i_head_wdata[7:0]}} : i_head_wdata;
        r_tag   <= i_head_tag;
        r_byte  <= i_head_byte;
      end
      if (r_state == LD_REQ && i_dmem_resp && !i_flush) r_result <= w_ld_data;
    end
  end
  // A committed store always completes; flush only suppresses the pop.
  assign o_ldst_re          = i_dmem_resp & ((r_state == LD_REQ) | (r_state == ST_REQ)) & ~i_flush;
  assign o_dmem_read        = r_dmem_read;
  assign o_dmem_write       = r_dmem_write;
  assign o_dmem_address     = w_req ? {r_addr[DATA_W-1:1], 1'b0} : '0;
  assign o_dmem_wdata       = r_dmem_write ? r_wdata : '0;
  assign o_dmem_byte_enable = w_req ? w_be : 2'b00;
  assign o_cdb_valid        = w_bcast;
  assign o_cdb_tag          = w_bcast ? r_tag : '0;
  assign o_cdb_data         = w_bcast ? r_result : '0;
  assign o_store_done       = (r_state == ST_REQ) & i_dmem_resp;
  assign o_store_done_tag   = o_store_done ? r_tag : '0;
  assign o_busy             = r_state != IDLE;
endmodule

// File: tb/tb_ldst_mem_issuer.sv
// tb_ldst_mem_issuer: cycle-by-cycle vector table for ldst_mem_issuer plus async-reset sequence.
module tb_ldst_mem_issuer;
  logic        clk = 0, reset_n = 0, flush, head_valid, head_ready, head_is_store, head_byte;
  logic [15:0] head_addr, head_wdata, dmem_address, dmem_wdata, dmem_rdata, cdb_data;
  logic [2:0]  head_tag, rob_head_tag, cdb_tag, store_done_tag;
  logic        rob_head_valid, ldst_re, dmem_read, dmem_write, dmem_resp, cdb_valid, cdb_grant;
  logic        store_done, busy;
  logic [1:0]  dmem_byte_enable;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  ldst_mem_issuer dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_flush(flush), .i_head_valid(head_valid),
    .i_head_ready(head_ready), .i_head_is_store(head_is_store), .i_head_byte(head_byte),
    .i_head_addr(head_addr), .i_head_wdata(head_wdata), .i_head_tag(head_tag),
    .i_rob_head_valid(rob_head_valid), .i_rob_head_tag(rob_head_tag), .o_ldst_re(ldst_re),
    .o_dmem_read(dmem_read), .o_dmem_write(dmem_write), .o_dmem_address(dmem_address),
    .o_dmem_wdata(dmem_wdata), .o_dmem_byte_enable(dmem_byte_enable), .i_dmem_resp(dmem_resp),
    .i_dmem_rdata(dmem_rdata), .o_cdb_valid(cdb_valid), .o_cdb_tag(cdb_tag), .o_cdb_data(cdb_data),
    .i_cdb_grant(cdb_grant), .o_store_done(store_done), .o_store_done_tag(store_done_tag), .o_busy(busy)
  );
  typedef struct packed {
    logic fl, hv, hr, st, by; logic [15:0] addr, wd; logic [2:0] tag;
    logic rv; logic [2:0] rt; logic resp; logic [15:0] rd; logic gnt;
  } in_t;
  typedef struct packed {
    logic re, mr, mw; logic [15:0] ma, mwd; logic [1:0] be;
    logic cv; logic [2:0] ct; logic [15:0] cd; logic sd; logic [2:0] sdt; logic busy;
  } out_t;
  typedef struct packed { in_t i; out_t o; } vec_t;
  vec_t vq[$];
  function automatic in_t fi(logic fl, hv, hr, st, by, logic [15:0] addr, wd, logic [2:0] tag,
                             logic rv, logic [2:0] rt, logic resp, logic [15:0] rd, logic gnt);
    return '{fl, hv, hr, st, by, addr, wd, tag, rv, rt, resp, rd, gnt};
  endfunction
  function automatic out_t fo(logic re, mr, mw, logic [15:0] ma, mwd, logic [1:0] be,
                              logic cv, logic [2:0] ct, logic [15:0] cd, logic sd,
                              logic [2:0] sdt, logic busy);
    return '{re, mr, mw, ma, mwd, be, cv, ct, cd, sd, sdt, busy};
  endfunction
  function automatic out_t act();
    return '{ldst_re, dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
             cdb_valid, cdb_tag, cdb_data, store_done, store_done_tag, busy};
  endfunction
  task automatic drive(in_t v);
    {flush, head_valid, head_ready, head_is_store, head_byte} = {v.fl, v.hv, v.hr, v.st, v.by};
    {head_addr, head_wdata, head_tag, rob_head_valid, rob_head_tag} = {v.addr, v.wd, v.tag, v.rv, v.rt};
    {dmem_resp, dmem_rdata, cdb_grant} = {v.resp, v.rd, v.gnt};
  endtask
  task automatic check(string name, out_t got, out_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got re=%b rd=%b wr=%b a=%h wd=%h be=%b cv=%b ct=%0d cd=%h sd=%b sdt=%0d busy=%b, want %h",
               name, got.re, got.mr, got.mw, got.ma, got.mwd, got.be, got.cv, got.ct, got.cd,
               got.sd, got.sdt, got.busy, exp);
    end
  endtask
  initial begin
    in_t  n = fi(0,0,0,0,0,0,0,0,0,0,0,0,0);
    out_t z = '0;
    vq.push_back('{fi(0,1,1,0,0,'h1235,0,3,0,0,0,0,0), z});
    vq.push_back('{fi(0,1,1,0,0,'h1235,0,3,0,0,0,0,0), fo(0,1,0,'h1234,0,2'b11,0,0,0,0,0,1)});
    vq.push_back('{fi(0,1,1,0,0,'h1235,0,3,0,0,0,0,0), fo(0,1,0,'h1234,0,2'b11,0,0,0,0,0,1)});
    vq.push_back('{fi(0,1,1,0,0,'h1235,0,3,0,0,1,'hBEEF,0), fo(1,1,0,'h1234,0,2'b11,0,0,0,0,0,1)});
    vq.push_back('{n, fo(0,0,0,0,0,0,1,3,'hBEEF,0,0,1)});
    vq.push_back('{n, fo(0,0,0,0,0,0,1,3,'hBEEF,0,0,1)});
    vq.push_back('{fi(0,0,0,0,0,0,0,0,0,0,0,0,1), fo(0,0,0,0,0,0,1,3,'hBEEF,0,0,1)});
    vq.push_back('{n, z});
    vq.push_back('{fi(0,1,1,0,1,'h2001,0,1,0,0,0,0,0), z});
    vq.push_back('{fi(0,1,1,0,1,'h2001,0,1,0,0,1,'h80FF,0), fo(1,1,0,'h2000,0,2'b10,0,0,0,0,0,1)});
    vq.push_back('{fi(0,0,0,0,0,0,0,0,0,0,0,0,1), fo(0,0,0,0,0,0,1,1,'hFF80,0,0,1)});
    vq.push_back('{fi(0,1,1,0,1,'h2000,0,2,0,0,0,0,0), z});
    vq.push_back('{fi(0,1,1,0,1,'h2000,0,2,0,0,1,'h80FF,0), fo(1,1,0,'h2000,0,2'b01,0,0,0,0,0,1)});
    vq.push_back('{fi(0,0,0,0,0,0,0,0,0,0,0,0,1), fo(0,0,0,0,0,0,1,2,'hFFFF,0,0,1)});
    vq.push_back('{fi(0,1,1,1,1,'h3001,'h00A5,5,1,4,0,0,0), z});
    vq.push_back('{fi(0,1,1,1,1,'h3001,'h00A5,5,1,4,0,0,0), z});
    vq.push_back('{fi(0,1,1,1,1,'h3001,'h00A5,5,1,5,0,0,0), z});
    vq.push_back('{fi(0,1,1,1,1,'h3001,'h00A5,5,1,5,0,0,0), fo(0,0,1,'h3000,'hA5A5,2'b10,0,0,0,0,0,1)});
    vq.push_back('{fi(0,1,1,1,1,'h3001,'h00A5,5,1,5,1,0,0), fo(1,0,1,'h3000,'hA5A5,2'b10,0,0,0,1,5,1)});
    vq.push_back('{n, z});
    vq.push_back('{fi(0,1,1,0,0,'h4444,0,6,0,0,0,0,0), z});
    vq.push_back('{fi(1,1,1,0,0,'h4444,0,6,0,0,0,0,0), fo(0,1,0,'h4444,0,2'b11,0,0,0,0,0,1)});
    vq.push_back('{n, fo(0,1,0,'h4444,0,2'b11,0,0,0,0,0,1)});
    vq.push_back('{n, fo(0,1,0,'h4444,0,2'b11,0,0,0,0,0,1)});
    vq.push_back('{fi(0,0,0,0,0,0,0,0,0,0,1,'h1234,0), fo(0,1,0,'h4444,0,2'b11,0,0,0,0,0,1)});
    vq.push_back('{n, z});
    vq.push_back('{fi(0,1,1,1,0,'h5556,'h1357,2,1,2,0,0,0), z});
    vq.push_back('{fi(1,1,1,1,0,'h5556,'h1357,2,1,2,1,0,0), fo(0,0,1,'h5556,'h1357,2'b11,0,0,0,1,2,1)});
    vq.push_back('{n, z});
    vq.push_back('{fi(0,1,1,0,0,'h6000,0,7,0,0,0,0,0), z});
    vq.push_back('{fi(0,1,1,0,0,'h6000,0,7,0,0,1,'h0042,0), fo(1,1,0,'h6000,0,2'b11,0,0,0,0,0,1)});
    vq.push_back('{fi(1,0,0,0,0,0,0,0,0,0,0,0,0), fo(0,0,0,0,0,0,1,7,'h0042,0,0,1)});
    vq.push_back('{n, z});
    vq.push_back('{fi(1,1,1,0,0,'h7000,0,1,0,0,0,0,0), z});
    vq.push_back('{fi(0,1,0,0,0,'h7000,0,1,0,0,0,0,0), z});
    vq.push_back('{fi(0,1,1,0,0,'h7000,0,1,0,0,0,0,0), z});
    vq.push_back('{fi(1,1,1,0,0,'h7000,0,1,0,0,1,'h5555,0), fo(0,1,0,'h7000,0,2'b11,0,0,0,0,0,1)});
    vq.push_back('{n, z});
    vq.push_back('{n, z});
    drive(n);
    repeat (2) @(posedge clk);
    #1 check("reset", act(), z);
    reset_n = 1;
    foreach (vq[k]) begin
      drive(vq[k].i);
      #4 check($sformatf("vec%0d", k), act(), vq[k].o);
      @(posedge clk); #1;
    end
    drive(fi(0,1,1,0,0,'h1235,0,3,0,0,0,0,0));
    @(posedge clk); #1;
    check("ld_before_rst", act(), fo(0,1,0,'h1234,0,2'b11,0,0,0,0,0,1));
    #2 reset_n = 0;
    #1 check("async_rst", act(), z);
    drive(n);
    @(posedge clk); #1 reset_n = 1;
    @(posedge clk); #1 check("after_rst", act(), z);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
